// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - FP16 field widths, constants and types shared by add_normalize
package fp16_pkg;

  localparam int FP16_EXP_W  = 5;
  localparam int FP16_FRAC_W = 10;
  localparam int SUM_W       = 14;

  localparam logic [FP16_EXP_W-1:0] EXP_MAX_VAL = 5'h1F;
  localparam logic [FP16_EXP_W-1:0] EXP_BIAS    = 5'd15;

  typedef struct packed {
    logic                   sign;
    logic [FP16_EXP_W-1:0]  exp;
    logic [FP16_FRAC_W-1:0] frac;
  } fp16_t;

  // [13] carry, [12] hidden bit, [11:2] mantissa, [1:0] guard bits
  typedef logic [SUM_W-1:0] sum14_t;

  function automatic fp16_t fp16_inf(input logic sign);
    return '{sign: sign, exp: EXP_MAX_VAL, frac: '0};
  endfunction

  function automatic fp16_t fp16_one(input logic sign);
    return '{sign: sign, exp: EXP_BIAS, frac: '0};
  endfunction

endpackage

// File: rtl/lzc13.sv
// rtl/lzc13.sv - combinational leading-zero counter for a 13-bit field
module lzc13 (
  input  logic [12:0] din,
  output logic [3:0]  count,
  output logic        zero
);

  // Scanning upward lets the highest set bit write last and win.
  always_comb begin
    count = 4'd13;
    for (int i = 0; i <= 12; i++) begin
      if (din[i]) count = 4'(12 - i);
    end
  end

  assign zero = ~|din;

endmodule

// File: rtl/add_normalize.sv
// rtl/add_normalize.sv - two-stage FP16 adder normalize/round/pack pipeline
// Define ADD_NORM_RNE_EN for round-to-nearest-even; default build truncates.
module add_normalize
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        nRST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign_in,
  input  logic [4:0]  exp_in,
  input  sum14_t      frac_sum,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] fp_out
);

  logic       s1_valid, s1_sign, s1_zero, s1_inf;
  logic [4:0] s1_e;
  logic [3:0] s1_shift;
  sum14_t     s1_frac;
  logic       s2_advance;

  assign s2_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s2_advance;

  logic [3:0] lz;
  logic       lz_zero;
  logic [4:0] e_eff, e_m1;
  logic [3:0] shift_amt;

  lzc13 u_lzc (
    .din   (frac_sum[12:0]),
    .count (lz),
    .zero  (lz_zero)
  );

  // Normalizing shift is capped so the exponent never drops below 1.
  assign e_eff     = (exp_in == 5'd0) ? 5'd1 : exp_in;
  assign e_m1      = e_eff - 5'd1;
  assign shift_amt = ({1'b0, lz} < e_m1) ? lz : e_m1[3:0];

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_inf   <= 1'b0;
      s1_e     <= '0;
      s1_shift <= '0;
      s1_frac  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign  <= sign_in;
        s1_zero  <= lz_zero && !frac_sum[13];
        s1_inf   <= (exp_in == EXP_MAX_VAL);
        s1_e     <= e_eff;
        s1_shift <= shift_amt;
        s1_frac  <= frac_sum;
      end
    end
  end

  logic [12:2] sh_hi;
  logic [5:0]  exp_pre, exp_fin;
  logic [9:0]  mant;
  logic        inc;
  logic [10:0] mant_r;
  fp16_t       result;

  assign sh_hi = 11'((s1_frac[12:0] << s1_shift) >> 2);

  always_comb begin
    if (s1_frac[13]) begin
      mant    = s1_frac[12:3];
      exp_pre = {1'b0, s1_e} + 6'd1;
    end else begin
      mant    = sh_hi[11:2];
      exp_pre = sh_hi[12] ? ({1'b0, s1_e} - {2'b00, s1_shift}) : 6'd0;
    end
  end

`ifdef ADD_NORM_RNE_EN
  logic [1:0] sh_lo;
  logic       guard_bit, sticky_bit;

  assign sh_lo      = 2'(s1_frac[12:0] << s1_shift);
  assign guard_bit  = s1_frac[13] ? s1_frac[2]    : sh_lo[1];
  assign sticky_bit = s1_frac[13] ? |s1_frac[1:0] : sh_lo[0];
  assign inc        = guard_bit & (sticky_bit | mant[0]);
`else
  assign inc = 1'b0;
`endif

  // A carry out of the mantissa leaves mant_r[9:0] zero and bumps the exponent.
  assign mant_r  = {1'b0, mant} + {10'd0, inc};
  assign exp_fin = exp_pre + {5'd0, mant_r[10]};

  always_comb begin
    result = '{sign: s1_sign, exp: exp_fin[4:0], frac: mant_r[9:0]};
    if (s1_inf || (exp_fin >= {1'b0, EXP_MAX_VAL})) begin
      result = fp16_inf(s1_sign);
    end else if (s1_zero) begin
      result = '0;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      out_valid <= 1'b0;
      fp_out    <= '0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) fp_out <= result;
    end
  end

endmodule

// File: tb/tb_add_normalize.sv
// tb/tb_add_normalize.sv - self-checking bench for add_normalize
module tb_add_normalize;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign_in = 1'b0;
  logic [4:0]  exp_in = '0;
  logic [13:0] frac_sum = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] fp_out;

`ifdef ADD_NORM_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  add_normalize dut (
    .clk       (clk),
    .nRST      (nRST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .frac_sum  (frac_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fp_out    (fp_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [4:0]  e;
    logic [13:0] f;
    logic [15:0] exp_fp;
  } vec_t;

  int n_checks = 0;
  int n_errs   = 0;
  int n_acc    = 0;
  int n_out    = 0;
  bit sb_en    = 1'b0;
  bit prev_stall = 1'b0;
  logic [15:0] prev_fp = '0;
  logic [15:0] exp_q[$];

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: normalize by doubling until the hidden bit is set or the
  // exponent floor is reached, then round and pack with integer arithmetic.
  function automatic logic [15:0] ref_fp(input logic s, input int ex, input int fr);
    int e, sh, n, m, g, st, eo;
    if (ex == 31) return {s, 5'h1F, 10'h000};
    if (fr == 0) return 16'h0000;
    e = (ex == 0) ? 1 : ex;
    if (fr >= 8192) begin
      m  = (fr >> 3) % 1024;
      g  = (fr >> 2) % 2;
      st = ((fr % 4) != 0) ? 1 : 0;
      eo = e + 1;
    end else begin
      n  = 0;
      sh = fr;
      while (n < e - 1 && sh < 4096) begin
        sh = sh * 2;
        n++;
      end
      eo = (sh >= 4096) ? e - n : 0;
      m  = (sh >> 2) % 1024;
      g  = (sh >> 1) % 2;
      st = sh % 2;
    end
    if (RNE && g == 1 && (st == 1 || (m % 2) == 1)) m++;
    if (m == 1024) begin
      m = 0;
      eo++;
    end
    if (eo >= 31) return {s, 5'h1F, 10'h000};
    return {s, eo[4:0], m[9:0]};
  endfunction

  function automatic logic [4:0] rand_exp();
    case ($urandom_range(0, 7))
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd31;
      3: return 5'd30;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  function automatic logic [13:0] rand_frac();
    case ($urandom_range(0, 3))
      0: return 14'($urandom_range(0, 16383));
      1: return 14'($urandom_range(0, 8191) >> $urandom_range(0, 12));
      2: return 14'($urandom_range(0, 15));
      default: return 14'($urandom_range(8176, 16383));
    endcase
  endfunction

  task automatic set_in(input logic s, input logic [4:0] e, input logic [13:0] f);
    sign_in  = s;
    exp_in   = e;
    frac_sum = f;
  endtask

  task automatic run_one(input logic s, input logic [4:0] e, input logic [13:0] f,
                         output logic [15:0] res, output int lat);
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_in(s, e, f);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    res = fp_out;
  endtask

  always @(negedge clk) begin
    if (!nRST) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else if (sb_en) begin
      if (prev_stall) begin
        check16("hold_valid", {15'd0, out_valid}, 16'd1);
        check16("hold_data", fp_out, prev_fp);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_fp(sign_in, int'(exp_in), int'(frac_sum)));
        n_acc++;
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errs++;
          $display("FAIL sb_extra: got result %h expected none", fp_out);
        end else begin
          check16("sb_result", fp_out, exp_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_fp    = fp_out;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[15];
    logic [15:0] res, held;
    int          lat, base_acc, base_out, cyc;
    bit          ghost;

    tbl[0]  = '{1'b0, 5'd15, 14'h1000, 16'h3C00};
    tbl[1]  = '{1'b0, 5'd15, 14'h2000, 16'h4000};
    tbl[2]  = '{1'b0, 5'd15, 14'h0800, 16'h3800};
    tbl[3]  = '{1'b0, 5'd1,  14'h0800, 16'h0200};
    tbl[4]  = '{1'b1, 5'd15, 14'h0000, 16'h0000};
    tbl[5]  = '{1'b0, 5'd30, 14'h2000, 16'h7C00};
    tbl[6]  = '{1'b1, 5'd31, 14'h1234, 16'hFC00};
    tbl[7]  = '{1'b0, 5'd15, 14'h1002, 16'h3C00};
    tbl[8]  = '{1'b0, 5'd15, 14'h1006, RNE ? 16'h3C02 : 16'h3C01};
    tbl[9]  = '{1'b0, 5'd15, 14'h1FFE, RNE ? 16'h4000 : 16'h3FFF};
    tbl[10] = '{1'b0, 5'd0,  14'h0001, 16'h0000};
    tbl[11] = '{1'b0, 5'd1,  14'h0FFE, RNE ? 16'h0400 : 16'h03FF};
    tbl[12] = '{1'b0, 5'd30, 14'h1FFE, RNE ? 16'h7C00 : 16'h7BFF};
    tbl[13] = '{1'b0, 5'd20, 14'h0001, 16'h2000};
    tbl[14] = '{1'b1, 5'd5,  14'h0010, 16'h8040};

    repeat (2) @(posedge clk);
    #1;
    check16("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check16("rst_fp_out", fp_out, 16'h0000);
    nRST = 1'b1;
    @(posedge clk); #1;
    check16("rst_in_ready", {15'd0, in_ready}, 16'd1);

    for (int i = 0; i < 15; i++) begin
      run_one(tbl[i].s, tbl[i].e, tbl[i].f, res, lat);
      check16($sformatf("vec%0d_fp", i), res, tbl[i].exp_fp);
      check16($sformatf("vec%0d_latency", i), 16'(lat), 16'd2);
    end

    // Backpressure: four operands with the output stalled.
    @(posedge clk); #1;
    sb_en    = 1'b1;
    base_acc = n_acc;
    base_out = n_out;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_in(1'b0, 5'd15, 14'h1000);
    @(negedge clk);
    check16("bp_ready_empty", {15'd0, in_ready}, 16'd1);
    @(posedge clk); #1;
    set_in(1'b1, 5'd16, 14'h2000);
    @(negedge clk);
    check16("bp_ready_one", {15'd0, in_ready}, 16'd1);
    @(posedge clk); #1;
    set_in(1'b0, 5'd10, 14'h0400);
    @(negedge clk);
    check16("bp_ready_full", {15'd0, in_ready}, 16'd0);
    check16("bp_out_valid", {15'd0, out_valid}, 16'd1);
    check16("bp_first_out", fp_out, 16'h3C00);
    held = fp_out;
    @(posedge clk); #1;
    @(negedge clk);
    check16("bp_still_full", {15'd0, in_ready}, 16'd0);
    check16("bp_stable", fp_out, held);
    check16("bp_accepted", 16'(n_acc - base_acc), 16'd2);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check16("bp_ready_resume", {15'd0, in_ready}, 16'd1);
    @(posedge clk); #1;
    set_in(1'b1, 5'd2, 14'h0100);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 20 && (n_out - base_out) < 4; k++) @(posedge clk);
    #1;
    check16("bp_out_count", 16'(n_out - base_out), 16'd4);
    check16("bp_in_count", 16'(n_acc - base_acc), 16'd4);

    // Reset with two operands in flight.
    sb_en = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_in(1'b0, 5'd15, 14'h1000);
    @(posedge clk); #1;
    set_in(1'b0, 5'd15, 14'h2000);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    nRST = 1'b0;
    #1;
    check16("rstmid_out_valid", {15'd0, out_valid}, 16'd0);
    check16("rstmid_fp_out", fp_out, 16'h0000);
    @(posedge clk); #1;
    nRST = 1'b1;
    out_ready = 1'b1;
    ghost = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) ghost = 1'b1;
    end
    check16("rstmid_no_ghost", {15'd0, ghost}, 16'd0);
    check16("rstmid_in_ready", {15'd0, in_ready}, 16'd1);

    // Randomized traffic against the reference model.
    sb_en    = 1'b1;
    base_acc = n_acc;
    base_out = n_out;
    cyc      = 0;
    while ((n_acc - base_acc) < 300 && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      set_in(1'($urandom), rand_exp(), rand_frac());
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    check16("rand_in_count_reached", {15'd0, (n_acc - base_acc) >= 300}, 16'd1);
    check16("rand_drained", 16'(exp_q.size()), 16'd0);
    check16("rand_out_count", 16'(n_out - base_out), 16'(n_acc - base_acc));
    sb_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
